fcs_check_arbiter: RTL

- Shares one byte-wide parallel FCS checker (start_of_frame / end_of_frame / data_in / fcs_error contract) among NUM_PORTS ingress byte streams.
- Grants whole frames round-robin and delays the granted stream by 4 bytes, so it can flag the first FCS byte with end_of_frame.
- Samples the checker verdict and reports one result per frame, tagged with port and length.
- Sits between the ingress MAC receive paths and the switch forwarding logic.

---
 rtl/fcs_check_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fcs_check_arbiter.sv
// Round-robin, frame-atomic sharing of one byte-wide FCS checker.
// A 4-byte delay line lets the first FCS byte be flagged with eof.
module fcs_check_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int CHECK_LATENCY = 2,
    parameter int LEN_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         in_valid,
    input  logic [8*NUM_PORTS-1:0]       in_data,
    input  logic [NUM_PORTS-1:0]         in_last,
    output logic [NUM_PORTS-1:0]         in_ready,
    output logic                         crc_start_of_frame,
    output logic                         crc_end_of_frame,
    output logic [7:0]                   crc_data_in,
    input  logic                         crc_fcs_error,
    output logic                         result_valid,
    output logic [$clog2(NUM_PORTS)-1:0] result_port,
    output logic                         result_fcs_error,
    output logic                         result_aborted,
    output logic [LEN_W-1:0]             result_length
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(CHECK_LATENCY + 4) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DRAIN,
        S_WAIT,
        S_REPORT,
        S_ABORT
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]    ptr, gnt, rr_idx;
    logic             rr_found;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [7:0]       s0, s1, s2, s3;
    logic [7:0]       cur_byte;
    logic             cur_valid, cur_last, accept, active;
    int               j;

    assign active    = (state == S_FILL) || (state == S_STREAM);
    assign cur_valid = in_valid[gnt];
    assign cur_last  = in_last[gnt];
    assign accept    = active && cur_valid;

    always_comb begin
        cur_byte = 8'h00;
        in_ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt == PW'(p)) begin
                cur_byte    = in_data[8*p +: 8];
                in_ready[p] = active;
            end
        end
    end

    // First requester at or after the pointer, searching upward with wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!rr_found && in_valid[j]) begin
                rr_found = 1'b1;
                rr_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        len_nxt = len;
        if (accept && (len != {LEN_W{1'b1}})) len_nxt = len + 1'b1;
    end

    assign crc_data_in = (state == S_STREAM || state == S_DRAIN) ? s3 : 8'h00;

    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        crc_start_of_frame = 1'b0;
        crc_end_of_frame   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rr_found) begin
                    state_nxt = S_FILL;
                    cnt_nxt   = '0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (cur_last) begin
                        state_nxt = S_ABORT;
                    end else if (cnt == CW'(3)) begin
                        crc_start_of_frame = 1'b1;
                        state_nxt          = S_STREAM;
                        cnt_nxt            = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (cnt != '0) begin
                    state_nxt = S_ABORT;
                end
            end
            // The checker has no valid qualifier, so a gap is fatal.
            S_STREAM: begin
                if (!cur_valid) begin
                    state_nxt = S_ABORT;
                end else if (cur_last) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                crc_end_of_frame = (cnt == '0);
                if (cnt == CW'(3)) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == CW'(CHECK_LATENCY - 1)) state_nxt = S_REPORT;
                else cnt_nxt = cnt + 1'b1;
            end
            S_REPORT, S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ptr              <= '0;
            gnt              <= '0;
            len              <= '0;
            s0               <= 8'h00;
            s1               <= 8'h00;
            s2               <= 8'h00;
            s3               <= 8'h00;
            result_valid     <= 1'b0;
            result_port      <= '0;
            result_fcs_error <= 1'b0;
            result_aborted   <= 1'b0;
            result_length    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && rr_found) begin
                gnt <= rr_idx;
                ptr <= (rr_idx == PW'(NUM_PORTS - 1)) ? '0 : rr_idx + 1'b1;
                len <= '0;
            end else begin
                len <= len_nxt;
            end
            if (accept) begin
                {s3, s2, s1, s0} <= {s2, s1, s0, cur_byte};
            end else if (state == S_DRAIN) begin
                {s3, s2, s1, s0} <= {s2, s1, s0, 8'h00};
            end
            result_valid <= 1'b0;
            if (state_nxt == S_ABORT) begin
                result_valid     <= 1'b1;
                result_port      <= gnt;
                result_aborted   <= 1'b1;
                result_fcs_error <= 1'b1;
                result_length    <= len_nxt;
            end else if (state_nxt == S_REPORT) begin
                result_valid     <= 1'b1;
                result_port      <= gnt;
                result_aborted   <= 1'b0;
                result_fcs_error <= crc_fcs_error;
                result_length    <= len_nxt;
            end
        end
    end

endmodule
